// File: rtl/axi4_lite_pkg.sv
// Shared types and defaults for the 4-register AXI4-Lite interface.
// Imported by the master (and any slave) with import axi4_lite_pkg::*.
package axi4_lite_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 32;

    localparam logic [3:0] WSTRB_ALL = 4'hF;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_DONE
    } mst_state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns single-beat local commands into AW/W/B or
// AR/R transactions, one outstanding at a time.
//
// Ports:
//   ACLK, ARESETn          clock, async active-low reset
//   cmd_valid/cmd_ready    local command handshake (ready only in IDLE)
//   cmd_write/addr/wdata   command direction, byte address, write data
//   done/resp/rdata        one-cycle completion strobe, captured response
//                          and read data (resp/rdata hold until next capture)
//   AW*/W*/B*/AR*/R*       AXI4-Lite master channels, all outputs registered
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              ACLK,
    input  logic              ARESETn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              done,
    output logic [1:0]        resp,
    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,

    output logic [DATA_W-1:0] WDATA,
    output logic [3:0]        WSTRB,
    output logic              WVALID,
    input  logic              WREADY,

    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,

    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,

    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY
);

    mst_state_e        state_q, state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              done_q, done_d;
    logic [1:0]        resp_q, resp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Per-channel completion including a handshake in the current cycle,
    // so AW and W finishing on the same edge still leaves WR_REQ.
    logic              aw_fin;
    logic              w_fin;

    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        done_d    = 1'b0;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        aw_fin    = aw_done_q | (awvalid_q & AWREADY);
        w_fin     = w_done_q | (wvalid_q & WREADY);

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                // Each VALID drops on its own handshake edge.
                awvalid_d = awvalid_q & ~AWREADY;
                wvalid_d  = wvalid_q & ~WREADY;
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                if (aw_fin && w_fin) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (BVALID) begin
                    resp_d   = BRESP;
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_RD_REQ: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (RVALID) begin
                    rdata_d  = RDATA;
                    resp_d   = RRESP;
                    rready_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= OKAY;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = done_q;
    assign resp      = resp_q;
    assign rdata     = rdata_q;
    assign AWADDR    = awaddr_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = WSTRB_ALL;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = araddr_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

Initiator end of the team's 4-register AXI4-Lite interface. Accepts single-beat read or write commands from a local command port and drives the AW/W/B channels (writes) or AR/R channels (reads) toward an AXI4-Lite slave. Returns read data and the slave response on a one-cycle completion strobe. Sits between a CPU/bus-bridge command source and the peripheral register slaves; one transaction is outstanding at a time.

## Interface
- ADDR_W, 4, byte address width; register index is addr[3:2]
- DATA_W, 32, data width
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  master idle, command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- done  out  1  one-cycle completion strobe
- resp  out  2  captured BRESP/RRESP, valid with done
- rdata  out  DATA_W  captured RDATA, valid with done on reads
- AWADDR out ADDR_W; AWVALID out 1; AWREADY in 1
- WDATA out DATA_W; WSTRB out 4 (constant 4'hF); WVALID out 1; WREADY in 1
- BRESP in 2; BVALID in 1; BREADY out 1
- ARADDR out ADDR_W; ARVALID out 1; ARREADY in 1
- RDATA in DATA_W; RRESP in 2; RVALID in 1; RREADY out 1

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE: cmd_ready=1. On accept, cmd_addr/cmd_wdata are latched into AWADDR/ARADDR and WDATA. Next state is WR_REQ (write) or RD_REQ (read).
- WR_REQ: AWVALID and WVALID are both asserted on entry, with no dependency on AWREADY/WREADY.
  - Each valid clears independently on the edge where its handshake completes (VALID && READY).
  - Flags aw_done/w_done track completion. The state leaves WR_REQ when both handshakes are complete, including when they complete in the same cycle.
- WR_RESP: BREADY=1. When BVALID is sampled high, capture BRESP and go to DONE.
- RD_REQ: ARVALID=1 until ARREADY is sampled high, then go to RD_DATA.
- RD_DATA: RREADY=1. When RVALID is sampled high, capture RDATA and RRESP and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. resp and rdata hold their values until the next capture.
- AWADDR, WDATA and ARADDR stay stable while the corresponding VALID is high (AXI rule).
- cmd_valid is ignored whenever the state is not IDLE.

## Timing
- All AXI outputs and done are registered. cmd_ready decodes combinationally from the state register.
- Reset values: state IDLE, cmd_ready 1, every VALID/READY output 0, done 0, resp 2'b00, rdata 0, AWADDR/ARADDR/WDATA 0.
- Zero-wait slave, write: accept at edge 0; AWVALID/WVALID high in cycle 1; BREADY high in cycle 2; done in cycle 3 at the earliest. Each slave wait cycle adds one cycle.
- Zero-wait slave, read: ARVALID in cycle 1; RREADY in cycle 2; done in cycle 3.
- A new command is accepted no earlier than the cycle after done.
- Reset asserted mid-transaction: all outputs return to their reset values immediately (asynchronous). No done is issued, and the in-flight transaction is abandoned.
- BVALID/RVALID that arrive before BREADY/RREADY is asserted are held by the slave. The master never drops a response.

## Structure
- Package axi4_lite_pkg holds:
  - resp_e: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - the master state enum
  - ADDR_W/DATA_W defaults
  - WSTRB_ALL = 4'hF
- Single module, no sub-module. The existing slave register block is reused as the DUT partner in the bench.

## Test plan
- Write addr 4'h4, data 32'hDEADBEEF, zero-wait slave -> AWADDR=4'h4 and WDATA=32'hDEADBEEF handshake in cycle 1; done in cycle 3 with resp=2'b00; slave slv_reg1 reads back 32'hDEADBEEF.
- Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID low after 1 cycle; AWVALID and AWADDR held stable for 4 cycles; exactly one done, after B.
- Read addr 4'h8, slave returns RDATA=32'h12345678 with RRESP=2'b00 after 2 wait cycles -> rdata=32'h12345678 and resp=2'b00 on the single done cycle.
- Write where slave returns BRESP=2'b10 after BVALID is delayed 5 cycles -> BREADY held high throughout; resp=SLVERR with done.
- cmd_valid held high during a write with a different address -> cmd_ready=0; second command accepted only in the cycle after done; no spurious AW/AR.
- ARESETn pulsed low in WR_RESP -> outputs reset asynchronously; done never asserts; next write completes normally.
